// File: rtl/seq_add_sub_if.sv
// seq_add_sub_if
//   Operation bus for the slice-serial adder/subtractor.
//   master : requester side  - drives start, A, B, Cin, M; sees S, Co, V, busy, done
//   slave  : arithmetic unit - sees start, A, B, Cin, M; drives S, Co, V, busy, done
//   Parameter WIDTH sets the operand/result width.
interface seq_add_sub_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             M;
  logic [WIDTH-1:0] S;
  logic             Co;
  logic             V;
  logic             busy;
  logic             done;

  modport master (
    output start, A, B, Cin, M,
    input  S, Co, V, busy, done
  );

  modport slave (
    input  start, A, B, Cin, M,
    output S, Co, V, busy, done
  );
endinterface

// File: rtl/seq_add_sub.sv
// seq_add_sub
//   Slice-serial two's-complement adder/subtractor. Operands are captured on
//   an accepted start and summed SLICE bits per clock, LSB slice first, with a
//   registered carry between slices. The result appears on S/Co/V together
//   with a one-cycle done pulse, N = WIDTH/SLICE edges after the start edge.
//   WIDTH must be an integer multiple of SLICE; SLICE = WIDTH is legal.
//
//   Ports
//     clk : rising-edge clock
//     rst : synchronous active-high reset (aborts any operation in flight)
//     bus : seq_add_sub_if.slave
//           start        request, accepted only in IDLE (incl. the done cycle)
//           A, B         operands
//           Cin          carry-in (M=0) / borrow-in (M=1)
//           M            0 add, 1 subtract
//           S, Co, V     registered result, carry-out (1 = no borrow), overflow
//           busy         high while RUN
//           done         one-cycle result-valid pulse
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | waiting for start; S/Co/V hold the last result
//   RUN   | one slice summed per edge; counter holds the slice index
module seq_add_sub #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input logic         clk,
  input logic         rst,
  seq_add_sub_if.slave bus
);

  localparam int N  = WIDTH / SLICE;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sh;   // operand A, shifted down one slice per edge
  logic [WIDTH-1:0] b_sh;   // B, already inverted for subtract
  logic [WIDTH-1:0] acc;    // partial sum, filled from the top
  logic             carry;

  logic [SLICE:0]         slice_sum;
  logic [WIDTH+SLICE-1:0] acc_cat;
  logic [WIDTH-1:0]       acc_next;
  logic                   v_next;

  assign slice_sum = {1'b0, a_sh[SLICE-1:0]} + {1'b0, b_sh[SLICE-1:0]}
                   + {{SLICE{1'b0}}, carry};

  // New slice enters at the top; after N edges the LSB slice sits at bit 0.
  assign acc_cat  = {slice_sum[SLICE-1:0], acc};
  assign acc_next = acc_cat[WIDTH+SLICE-1:SLICE];

  // On the last slice the MSB operand bits are at SLICE-1. Carry into the
  // MSB is a^b^s there, so overflow = a^b^s^carry_out.
  assign v_next = a_sh[SLICE-1] ^ b_sh[SLICE-1] ^ slice_sum[SLICE-1] ^ slice_sum[SLICE];

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      a_sh     <= '0;
      b_sh     <= '0;
      acc      <= '0;
      carry    <= 1'b0;
      bus.S    <= '0;
      bus.Co   <= 1'b0;
      bus.V    <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_sh     <= bus.A;
            b_sh     <= bus.M ? ~bus.B : bus.B;
            carry    <= bus.Cin ^ bus.M;
            cnt      <= '0;
            state    <= RUN;
            bus.busy <= 1'b1;
          end
        end
        RUN: begin
          a_sh  <= a_sh >> SLICE;
          b_sh  <= b_sh >> SLICE;
          acc   <= acc_next;
          carry <= slice_sum[SLICE];
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) begin
            state    <= IDLE;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
            bus.S    <= acc_next;
            bus.Co   <= slice_sum[SLICE];
            bus.V    <= v_next;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/seq_add_sub.md
SEQ_ADD_SUB -- requirements
Module: seq_add_sub

Interface
REQ-001 SHALL provide parameter WIDTH, default 16, operand/result width in bits.
REQ-002 SHALL provide parameter SLICE, default 4, bits processed per clock; WIDTH SHALL be an integer multiple of SLICE; N = WIDTH/SLICE.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port start  input  1  request to begin an operation.
REQ-006 SHALL have port A  input  WIDTH  minuend/addend.
REQ-007 SHALL have port B  input  WIDTH  subtrahend/addend.
REQ-008 SHALL have port Cin  input  1  carry-in (M=0) or borrow-in (M=1).
REQ-009 SHALL have port M  input  1  mode: 0 add, 1 subtract.
REQ-010 SHALL have port S  output  WIDTH  registered result.
REQ-011 SHALL have port Co  output  1  registered carry-out; for subtract, 1 = no borrow.
REQ-012 SHALL have port V  output  1  registered two's-complement overflow.
REQ-013 SHALL have port busy  output  1  high while an operation is in progress.
REQ-014 SHALL have port done  output  1  one-cycle pulse marking S/Co/V valid.

Function
REQ-015 SHALL implement FSM states IDLE and RUN plus a slice counter of ceil(log2(N+1)) bits.
REQ-016 In IDLE, start=1 at a rising edge SHALL capture A, B, Cin, M into internal registers, clear the counter and enter RUN.
REQ-017 M=0 SHALL compute {Co,S} = A + B + Cin; M=1 SHALL compute {Co,S} = A + ~B + ~Cin (i.e. A - B - Cin).
REQ-018 Each RUN edge SHALL add one SLICE-bit slice, LSB slice first, using the registered carry from the previous slice; the first slice uses Cin (M=0) or ~Cin (M=1).
REQ-019 After the Nth slice edge (edge t+N for start sampled at edge t) the FSM SHALL return to IDLE and S, Co, V SHALL be updated together, with done=1 for exactly that cycle.
REQ-020 V SHALL equal carry into MSB XOR carry out of MSB.
REQ-021 busy SHALL be 1 in every cycle the FSM is in RUN, 0 otherwise; done and busy SHALL never both be 1.
REQ-022 start while busy=1 SHALL be ignored with no effect on captured operands, counter or outputs.
REQ-023 start in the cycle done=1 SHALL be accepted, giving one result every N+1 cycles back-to-back.
REQ-024 A, B, Cin, M changing during RUN SHALL not affect the result in flight.
REQ-025 S, Co, V SHALL hold their last values between done pulses; partial sums SHALL not appear on S.
REQ-026 SLICE=WIDTH (N=1) SHALL be legal: done at edge t+1.

Reset
REQ-027 rst=1 at a rising edge SHALL force IDLE, counter 0, S=0, Co=0, V=0, busy=0, done=0, overriding start.
REQ-028 rst asserted during RUN SHALL abort the operation; no done pulse SHALL follow for it.
REQ-029 After rst deasserts, the first start SHALL behave exactly as REQ-016.

Verification (WIDTH=16, SLICE=4 unless stated)
REQ-030 A=FFFF, B=0003, Cin=0, M=0, start pulse -> busy for 4 cycles, done at edge t+4, S=0002, Co=1, V=0.
REQ-031 A=7FFF, B=0001, Cin=0, M=0 -> S=8000, Co=0, V=1; then A=8000, B=0001, M=1 -> S=7FFF, Co=1, V=1.
REQ-032 A=0005, B=0007, Cin=0, M=1 -> S=FFFE, Co=0, V=0; same with Cin=1 -> S=FFFD, Co=0.
REQ-033 start pulsed again 2 cycles after start with different A/B, and A/B toggled during RUN -> ignored; result matches first operands.
REQ-034 rst at edge t+2 of an operation -> all outputs 0 next cycle, no done; fresh start then completes normally.
REQ-035 Back-to-back starts held high continuously -> done every 5 cycles with correct results; repeat with SLICE=16 -> done every 2 cycles.
